pcie_tx_err_chk: RTL and testbench

Parametrised PCIe TX-path error checker: snoops the AXI-S TX stream (PCIe SS power-user header format) toward the PCIe subsystem and the completion-timeout sideband, detects protocol violations, and queues one error record per violation for the error-reporting logic. It generalises the TX error checker to any data width and to configurable MPS/MRRS limits. It adds an error-record FIFO with ready/valid output, an overflow flag and a saturating error counter.

---
 rtl/pcie_err_chk_pkg.sv | 43 ++++
 rtl/pcie_err_rec_fifo.sv | 64 ++++++
 rtl/pcie_tx_err_chk.sv | 172 +++++++++++++++++
 tb/tb_pcie_tx_err_chk.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_err_chk_pkg.sv
// Shared definitions for the PCIe TX error checker: error-code bit positions,
// fmt_type encodings, the queued error record and the expected-beat helper.
package pcie_err_chk_pkg;

  localparam int ERR_BEATS = 0;
  localparam int ERR_MPS   = 1;
  localparam int ERR_MRRS  = 2;
  localparam int ERR_4K    = 3;
  localparam int ERR_CPLTO = 4;
  localparam int ERR_FMT   = 5;

  localparam logic [7:0] FT_MRD32 = 8'h00;
  localparam logic [7:0] FT_MRD64 = 8'h20;
  localparam logic [7:0] FT_MWR32 = 8'h40;
  localparam logic [7:0] FT_MWR64 = 8'h60;
  localparam logic [7:0] FT_CPL   = 8'h0A;
  localparam logic [7:0] FT_CPLD  = 8'h4A;
  // Msg/MsgD carry the routing sub-field in fmt_type[2:0]; match on [7:3].
  localparam logic [4:0] FT_MSG_HI  = 5'b00110;
  localparam logic [4:0] FT_MSGD_HI = 5'b01110;

  typedef struct packed {
    logic [255:0] hdr;
    logic [2:0]   pf;
    logic [10:0]  vf;
    logic         vf_active;
    logic [31:0]  code;
  } t_err_rec;

  function automatic logic [15:0] exp_beats(input logic [7:0] fmt_type,
                                            input logic [9:0] len,
                                            input int         data_w);
    int len_dw;
    int bytes;
    int bpb;
    if (!fmt_type[6]) return 16'd1;
    len_dw = (len == 10'd0) ? 1024 : int'(len);
    bytes  = 32 + 4 * len_dw;
    bpb    = data_w / 8;
    return 16'((bytes + bpb - 1) / bpb);
  endfunction

endpackage

// File: rtl/pcie_err_rec_fifo.sv
// Synchronous FIFO of error records; the head record sits in an output
// register so it is stable while the consumer stalls.
module pcie_err_rec_fifo
  import pcie_err_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  t_err_rec i_rec,
  input  logic     i_pop,
  output t_err_rec o_rec,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  t_err_rec        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_out_vld;
  t_err_rec        r_out_rec;

  logic            w_pop;
  logic            w_push_ok;
  logic [AW-1:0]   w_rd_nxt;
  logic [AW:0]     w_cnt_nxt;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = ~r_out_vld;
  assign o_rec     = r_out_rec;
  assign w_pop     = i_pop & r_out_vld;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
  assign w_cnt_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);

  // NOTE: storage has no reset; occupancy is tracked by the pointers and
  // count, so resetting the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_out_rec <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_cnt_nxt;
      r_out_vld <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0)
        r_out_rec <= (w_push_ok && (r_wr_ptr == w_rd_nxt)) ? i_rec : r_mem[w_rd_nxt];
    end
  end

endmodule

// File: rtl/pcie_tx_err_chk.sv
// Snoops the PCIe TX AXI-S stream and completion-timeout sideband, and queues
// one error record per detected violation with overflow and count tracking.
module pcie_tx_err_chk
  import pcie_err_chk_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int MPS_BYTES  = 512,
  parameter int MRRS_BYTES = 512,
  parameter int ERR_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_tvalid,
  input  logic              tx_tready,
  input  logic              tx_tlast,
  input  logic [DATA_W-1:0] tx_tdata,
  input  logic              cplto_valid,
  input  logic [9:0]        cplto_tag,
  input  logic [2:0]        cplto_pf,
  input  logic [10:0]       cplto_vf,
  input  logic              cplto_vf_active,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [255:0]      err_hdr,
  output logic [2:0]        err_pf,
  output logic [10:0]       err_vf,
  output logic              err_vf_active,
  output logic [31:0]       err_code,
  output logic              err_overflow,
  output logic [15:0]       err_cnt,
  input  logic              clr
);

  localparam logic [12:0] LP_MPS  = 13'(MPS_BYTES);
  localparam logic [12:0] LP_MRRS = 13'(MRRS_BYTES);

  logic          r_sop;
  logic [255:0]  r_hdr;
  logic [15:0]   r_beat_cnt;
  logic          r_tx_vld, r_cpl_vld, r_pend_vld;
  t_err_rec      r_tx_rec, r_cpl_rec, r_pend_rec;
  logic          r_overflow;
  logic [15:0]   r_cnt;

  logic          w_hs;
  logic [255:0]  w_hdr;
  logic [15:0]   w_beats;
  logic [7:0]    w_fmt;
  logic [9:0]    w_len;
  logic [12:0]   w_bytes;
  logic [11:0]   w_addr_lo;
  logic          w_is_mrd, w_is_mwr, w_is_cpld, w_supported;
  logic [31:0]   w_code;
  logic          w_tx_det;
  logic          w_push_vld;
  t_err_rec      w_push_rec;
  logic          w_fifo_full, w_fifo_empty, w_can_push;
  logic          w_tx_lose, w_pend_busy, w_drop;
  logic [1:0]    w_inc;
  logic [16:0]   w_cnt_sum;
  t_err_rec      w_fifo_rec;
  logic          w_unused_tdata;

  assign w_hs    = tx_tvalid & tx_tready;
  // On the SOP beat the header is still on the bus, not yet in r_hdr.
  assign w_hdr   = r_sop ? tx_tdata[255:0] : r_hdr;
  assign w_beats = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;
  assign w_fmt   = w_hdr[31:24];
  assign w_len   = w_hdr[9:0];
  assign w_bytes = (w_len == 10'd0) ? 13'd4096 : {1'b0, w_len, 2'b00};
  assign w_addr_lo = w_fmt[5] ? {w_hdr[107:98], 2'b00} : {w_hdr[75:66], 2'b00};
  assign w_unused_tdata = ^tx_tdata;

  assign w_is_mrd    = (w_fmt == FT_MRD32) || (w_fmt == FT_MRD64);
  assign w_is_mwr    = (w_fmt == FT_MWR32) || (w_fmt == FT_MWR64);
  assign w_is_cpld   = (w_fmt == FT_CPLD);
  assign w_supported = w_is_mrd || w_is_mwr || w_is_cpld || (w_fmt == FT_CPL) ||
                       (w_fmt[7:3] == FT_MSG_HI) || (w_fmt[7:3] == FT_MSGD_HI);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_code = '0;
    w_code[ERR_BEATS] = (w_beats != exp_beats(w_fmt, w_len, DATA_W));
    w_code[ERR_MPS]   = (w_is_mwr || w_is_cpld) && (w_bytes > LP_MPS);
    w_code[ERR_MRRS]  = w_is_mrd && (w_bytes > LP_MRRS);
    w_code[ERR_4K]    = (w_is_mrd || w_is_mwr) && (({1'b0, w_addr_lo} + w_bytes) > 13'd4096);
    w_code[ERR_FMT]   = ~w_supported;
  end

  assign w_tx_det = w_hs & tx_tlast & (w_code != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sop      <= 1'b1;
      r_hdr      <= '0;
      r_beat_cnt <= '0;
      r_tx_vld   <= 1'b0;
      r_tx_rec   <= '0;
      r_cpl_vld  <= 1'b0;
      r_cpl_rec  <= '0;
    end else begin
      if (w_hs) begin
        r_sop      <= tx_tlast;
        r_beat_cnt <= tx_tlast ? 16'd0 : w_beats;
        if (r_sop) r_hdr <= tx_tdata[255:0];
      end
      r_tx_vld  <= w_tx_det;
      r_tx_rec  <= '{hdr: w_hdr, pf: w_hdr[162:160], vf: w_hdr[173:163],
                     vf_active: w_hdr[174], code: w_code};
      r_cpl_vld <= cplto_valid;
      r_cpl_rec <= '{hdr: {246'd0, cplto_tag}, pf: cplto_pf, vf: cplto_vf,
                     vf_active: cplto_vf_active, code: 32'(1) << ERR_CPLTO};
    end
  end

  // Push priority: completion timeout, then pending TX record, then fresh TX.
  always_comb begin
    w_push_vld = 1'b1;
    w_push_rec = r_tx_rec;
    if (r_cpl_vld)       w_push_rec = r_cpl_rec;
    else if (r_pend_vld) w_push_rec = r_pend_rec;
    else                 w_push_vld = r_tx_vld;
  end

  assign w_can_push  = ~w_fifo_full | (err_valid & err_ready);
  assign w_tx_lose   = r_tx_vld & (r_cpl_vld | r_pend_vld);
  assign w_pend_busy = r_pend_vld & r_cpl_vld;
  assign w_drop      = (w_push_vld & ~w_can_push) | (w_tx_lose & w_pend_busy);

  assign w_inc     = {1'b0, w_tx_det} + {1'b0, cplto_valid};
  assign w_cnt_sum = {1'b0, r_cnt} + 17'(w_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_rec <= '0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pend_vld <= w_tx_lose | w_pend_busy;
      if (w_tx_lose && !w_pend_busy) r_pend_rec <= r_tx_rec;
      if (w_drop)   r_overflow <= 1'b1;
      else if (clr) r_overflow <= 1'b0;
      if (clr)      r_cnt <= {14'd0, w_inc};
      else          r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  pcie_err_rec_fifo #(.DEPTH(ERR_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_vld & w_can_push),
    .i_rec   (w_push_rec),
    .i_pop   (err_ready),
    .o_rec   (w_fifo_rec),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign err_valid     = ~w_fifo_empty;
  assign err_hdr       = w_fifo_rec.hdr;
  assign err_pf        = w_fifo_rec.pf;
  assign err_vf        = w_fifo_rec.vf;
  assign err_vf_active = w_fifo_rec.vf_active;
  assign err_code      = w_fifo_rec.code;
  assign err_overflow  = r_overflow;
  assign err_cnt       = r_cnt;

endmodule

// File: tb/tb_pcie_tx_err_chk.sv
// Directed bench for pcie_tx_err_chk at DATA_W=512, MPS=MRRS=512, depth 8.
module tb_pcie_tx_err_chk;

  localparam int DATA_W = 512;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_tvalid, tx_tready, tx_tlast;
  logic [DATA_W-1:0] tx_tdata;
  logic              cplto_valid;
  logic [9:0]        cplto_tag;
  logic [2:0]        cplto_pf;
  logic [10:0]       cplto_vf;
  logic              cplto_vf_active;
  logic              err_valid, err_ready;
  logic [255:0]      err_hdr;
  logic [2:0]        err_pf;
  logic [10:0]       err_vf;
  logic              err_vf_active;
  logic [31:0]       err_code;
  logic              err_overflow;
  logic [15:0]       err_cnt;
  logic              clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcie_tx_err_chk #(
    .DATA_W(DATA_W), .MPS_BYTES(512), .MRRS_BYTES(512), .ERR_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata),
    .cplto_valid(cplto_valid), .cplto_tag(cplto_tag), .cplto_pf(cplto_pf),
    .cplto_vf(cplto_vf), .cplto_vf_active(cplto_vf_active),
    .err_valid(err_valid), .err_ready(err_ready), .err_hdr(err_hdr),
    .err_pf(err_pf), .err_vf(err_vf), .err_vf_active(err_vf_active),
    .err_code(err_code), .err_overflow(err_overflow), .err_cnt(err_cnt), .clr(clr)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] make_hdr(input logic [7:0] fmt, input logic [9:0] len,
                                            input logic [63:0] addr, input logic [2:0] pf,
                                            input logic [10:0] vf, input logic act);
    logic [255:0] h;
    h = '0;
    h[31:24] = fmt;
    h[9:0]   = len;
    if (fmt[5]) begin
      h[95:64]  = addr[63:32];
      h[127:98] = addr[31:2];
    end else begin
      h[95:66]  = addr[31:2];
    end
    h[162:160] = pf;
    h[173:163] = vf;
    h[174]     = act;
    return h;
  endfunction

  // One handshaked beat driven at negedge; returns at the next negedge.
  task automatic beat(input logic [255:0] data, input logic last);
    tx_tdata  = {~data, data};
    tx_tvalid = 1'b1;
    tx_tready = 1'b1;
    tx_tlast  = last;
    @(negedge clk);
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [255:0] hdr, input logic [2:0] pf,
                            input logic [10:0] vf, input logic act, input logic [31:0] code);
    for (int i = 0; i < 20 && !err_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 256'(err_valid), 256'(1));
    check({tag, "_hdr"},   err_hdr, hdr);
    check({tag, "_pf"},    256'(err_pf), 256'(pf));
    check({tag, "_vf"},    256'(err_vf), 256'(vf));
    check({tag, "_vfact"}, 256'(err_vf_active), 256'(act));
    check({tag, "_code"},  256'(err_code), 256'(code));
    err_ready = 1'b1;
    @(negedge clk);
    err_ready = 1'b0;
  endtask

  logic [255:0] h_ok, h_bad, h_mrd, h_mrd0, h_long, h_mrd32;
  int pops;

  initial begin
    rst = 1'b1; tx_tvalid = 0; tx_tready = 0; tx_tlast = 0; tx_tdata = '0;
    cplto_valid = 0; cplto_tag = '0; cplto_pf = '0; cplto_vf = '0; cplto_vf_active = 0;
    err_ready = 0; clr = 0;
    h_ok    = make_hdr(8'h60, 10'd16,  64'h1000, 3'd0, 11'd0, 1'b0);
    h_bad   = make_hdr(8'h60, 10'd16,  64'h1000, 3'd1, 11'd7, 1'b1);
    h_mrd   = make_hdr(8'h20, 10'd256, 64'hF80,  3'd0, 11'd0, 1'b0);
    h_mrd0  = make_hdr(8'h20, 10'd0,   64'hF80,  3'd4, 11'd2, 1'b0);
    h_long  = make_hdr(8'h60, 10'd48,  64'h2000, 3'd0, 11'd0, 1'b0);
    h_mrd32 = make_hdr(8'h00, 10'd1,   64'h0,    3'd0, 11'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_valid", 256'(err_valid), 256'(0));
    check("rst_code",  256'(err_code), 256'(0));
    check("rst_hdr",   err_hdr, 256'(0));
    check("rst_ovf",   256'(err_overflow), 256'(0));
    check("rst_cnt",   256'(err_cnt), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Clean 2-beat MWr64.
    beat(h_ok, 1'b0);
    beat(256'hDEAD_BEEF, 1'b1);
    repeat (4) @(negedge clk);
    check("clean_valid", 256'(err_valid), 256'(0));
    check("clean_cnt",   256'(err_cnt), 256'(0));

    // MWr64 len 16 ending after one beat: latency and hold checks.
    beat(h_bad, 1'b1);
    check("short_n1_valid", 256'(err_valid), 256'(0));
    check("short_n1_cnt",   256'(err_cnt), 256'(1));
    @(negedge clk);
    check("short_n2_valid", 256'(err_valid), 256'(1));
    repeat (2) @(negedge clk);
    check("short_hold_code", 256'(err_code), 256'(32'h1));
    pop_expect("short", h_bad, 3'd1, 11'd7, 1'b1, 32'h1);

    // MRd64 over MRRS and across 4 KB, len 256 and len 0.
    beat(h_mrd, 1'b1);
    pop_expect("mrd256", h_mrd, 3'd0, 11'd0, 1'b0, 32'h0C);
    beat(h_mrd0, 1'b1);
    pop_expect("mrd0", h_mrd0, 3'd4, 11'd2, 1'b0, 32'h0C);
    check("mrd_cnt", 256'(err_cnt), 256'(3));

    // Completion timeout in the same cycle as a malformed tlast.
    cplto_valid = 1'b1; cplto_tag = 10'h155; cplto_pf = 3'd2; cplto_vf = 11'd5;
    cplto_vf_active = 1'b1;
    beat(h_bad, 1'b1);
    cplto_valid = 1'b0;
    pop_expect("cplto", 256'h155, 3'd2, 11'd5, 1'b1, 32'h10);
    pop_expect("after_cplto", h_bad, 3'd1, 11'd7, 1'b1, 32'h1);
    check("cplto_cnt", 256'(err_cnt), 256'(5));

    // clr coinciding with a detection leaves the count at 1.
    clr = 1'b1;
    beat(h_bad, 1'b1);
    clr = 1'b0;
    check("clr_coinc_cnt", 256'(err_cnt), 256'(1));
    pop_expect("clr_coinc", h_bad, 3'd1, 11'd7, 1'b1, 32'h1);

    // Overflow: DEPTH+2 errors with the consumer stalled.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("pre_ovf_cnt", 256'(err_cnt), 256'(0));
    for (int i = 0; i < DEPTH + 2; i++) beat(h_bad, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_flag", 256'(err_overflow), 256'(1));
    check("ovf_cnt",  256'(err_cnt), 256'(DEPTH + 2));
    pops = 0;
    err_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (err_valid) pops++;
      @(negedge clk);
    end
    err_ready = 1'b0;
    check("ovf_pops", 256'(pops), 256'(DEPTH));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_ovf", 256'(err_overflow), 256'(0));
    check("clr_cnt", 256'(err_cnt), 256'(0));

    // Reset in the middle of a 4-beat TLP, then a clean single-beat MRd32.
    beat(h_long, 1'b0);
    beat(256'h1234, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    beat(h_mrd32, 1'b1);
    repeat (4) @(negedge clk);
    check("rst_mid_valid", 256'(err_valid), 256'(0));
    check("rst_mid_cnt",   256'(err_cnt), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
